// File: rtl/psc_trigger_receiver.sv
// psc_trigger_receiver: oversampling serial word receiver, 4-byte packet delineator and trigger decoder
// Ports: clk, reset (async, active-high), psc_input (async serial line, idle low);
//        trigger_out/rx_valid/frame_err/crc_err/timeout_err single-clk pulses, rx_cmd/rx_seq held packet fields.
// Build option: define PSC_RX_CRC_EN to check the packet CRC-8; otherwise the CRC byte is received and ignored.
module psc_trigger_receiver #(
  parameter int         OVERSAMPLE = 5,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter logic [7:0] TRIG_CMD   = 8'h54,
  parameter int         TIMEOUT    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic       trigger_out,
  output logic       rx_valid,
  output logic [7:0] rx_cmd,
  output logic [7:0] rx_seq,
  output logic       frame_err,
  output logic       crc_err,
  output logic       timeout_err
);
  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
  typedef enum logic [1:0] {HUNT, CMD, SEQ, CRC} pkt_state_t;
  bit_state_t    bit_q;
  pkt_state_t    pkt_q;
  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q, cmd_stg_q, seq_stg_q, rx_cmd_q, rx_seq_q;
  logic [TW-1:0] tcnt_q;
  logic          byte_done_q, frame_err_q, trig_q, valid_q, to_q, crc_ok;
  // sync_q[1:0] is the 2-FF synchronizer; sync_q[2] only delays the synced line for edge detection
  wire line = sync_q[1];
  wire rise = sync_q[1] & ~sync_q[2];
  wire tick = cnt_q == CW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[1:0], psc_input};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bit_q       <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (bit_q)
        IDLE: if (rise) begin
          bit_q <= START;
          cnt_q <= HALF;
        end
        START: if (tick) begin
          bit_q <= line ? DATA : IDLE;
          cnt_q <= FULL;
          idx_q <= '0;
        end else cnt_q <= cnt_q - 1'b1;
        DATA: if (tick) begin
          shift_q <= {shift_q[6:0], line};
          cnt_q   <= FULL;
          idx_q   <= idx_q + 1'b1;
          bit_q   <= idx_q == 3'd7 ? STOP : DATA;
        end else cnt_q <= cnt_q - 1'b1;
        STOP: if (tick) begin
          byte_done_q <= ~line;
          frame_err_q <= line;
          bit_q       <= IDLE;
        end else cnt_q <= cnt_q - 1'b1;
      endcase
    end
`ifdef PSC_RX_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_err_q;
  // running CRC restarts from zero on the SYNC byte, so no explicit clear is needed between packets
  always_comb begin
    crc_d = (pkt_q == HUNT ? 8'h00 : crc_q) ^ shift_q;
    for (int i = 0; i < 8; i++) crc_d = {crc_d[6:0], 1'b0} ^ (crc_d[7] ? 8'h07 : 8'h00);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= byte_done_q && pkt_q == CRC && shift_q != crc_q;
      if (byte_done_q) crc_q <= crc_d;
    end
  assign crc_ok  = shift_q == crc_q;
  assign crc_err = crc_err_q;
`else
  assign crc_ok  = 1'b1;
  assign crc_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pkt_q     <= HUNT;
      tcnt_q    <= '0;
      cmd_stg_q <= '0;
      seq_stg_q <= '0;
      rx_cmd_q  <= '0;
      rx_seq_q  <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      if (frame_err_q) begin
        pkt_q  <= HUNT;
        tcnt_q <= '0;
      end else if (byte_done_q) begin
        // a byte arriving on the expiry cycle takes priority over the timeout
        tcnt_q <= '0;
        case (pkt_q)
          HUNT: pkt_q <= shift_q == SYNC_BYTE ? CMD : HUNT;
          CMD: begin
            cmd_stg_q <= shift_q;
            pkt_q     <= SEQ;
          end
          SEQ: begin
            seq_stg_q <= shift_q;
            pkt_q     <= CRC;
          end
          CRC: begin
            pkt_q <= HUNT;
            if (crc_ok) begin
              rx_cmd_q <= cmd_stg_q;
              rx_seq_q <= seq_stg_q;
              valid_q  <= 1'b1;
              trig_q   <= cmd_stg_q == TRIG_CMD;
            end
          end
        endcase
      end else if (pkt_q != HUNT) begin
        tcnt_q <= tcnt_q + 1'b1;
        if (tcnt_q == TW'(TIMEOUT - 1)) begin
          to_q   <= 1'b1;
          pkt_q  <= HUNT;
          tcnt_q <= '0;
        end
      end
    end
  assign trigger_out = trig_q;
  assign rx_valid    = valid_q;
  assign rx_cmd      = rx_cmd_q;
  assign rx_seq      = rx_seq_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_psc_trigger_receiver.sv
// tb_psc_trigger_receiver: directed bench for the PSC trigger receiver
module tb_psc_trigger_receiver;
  localparam int OS = 5;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       psc_input = 1'b0;
  logic       trigger_out, rx_valid, frame_err, crc_err, timeout_err;
  logic [7:0] rx_cmd, rx_seq;
  int errors = 0, checks = 0;
  int n_trig = 0, n_valid = 0, n_frame = 0, n_crc = 0, n_to = 0;
  int b_trig, b_valid, b_frame, b_crc, b_to;

  psc_trigger_receiver dut (
    .clk(clk), .reset(reset), .psc_input(psc_input), .trigger_out(trigger_out),
    .rx_valid(rx_valid), .rx_cmd(rx_cmd), .rx_seq(rx_seq), .frame_err(frame_err),
    .crc_err(crc_err), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  // pulse cycle counters; a pulse wider than one clk counts more than once
  always @(negedge clk) begin
    if (trigger_out === 1'b1) n_trig++;
    if (rx_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_frame++;
    if (crc_err === 1'b1) n_crc++;
    if (timeout_err === 1'b1) n_to++;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic snap();
    b_trig = n_trig; b_valid = n_valid; b_frame = n_frame; b_crc = n_crc; b_to = n_to;
  endtask

  task automatic send_word(input logic [7:0] b, input logic stop = 1'b0);
    logic [9:0] w;
    w = {1'b1, b, stop};
    for (int i = 9; i >= 0; i--) begin
      psc_input = w[i];
      repeat (OS) @(negedge clk);
    end
  endtask

  task automatic send_packet(input logic [7:0] c, input logic [7:0] s, input logic [7:0] k);
    send_word(8'hA5);
    send_word(c);
    send_word(s);
    send_word(k);
  endtask

  task automatic idle(input int n);
    psc_input = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({trigger_out, rx_valid, frame_err, crc_err, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 00000", {trigger_out, rx_valid, frame_err, crc_err, timeout_err});
    end
    checks++;
    if ({rx_cmd, rx_seq} !== 16'h0) begin
      errors++; $display("FAIL reset_fields: got %h want 0000", {rx_cmd, rx_seq});
    end
    reset = 1'b0;
    idle(30);
    #1;
    checks++;
    if (n_trig + n_valid + n_frame + n_crc + n_to !== 0) begin
      errors++; $display("FAIL reset_quiet: got %0d pulses want 0", n_trig + n_valid + n_frame + n_crc + n_to);
    end
  endtask

  task automatic test_clean_packet();
    snap();
    send_packet(8'h54, 8'h07, 8'hC5);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL clean_early: rx_valid got %b want 0", rx_valid);
    end
    @(negedge clk);
    checks++;
    if ({trigger_out, rx_valid} !== 2'b11) begin
      errors++; $display("FAIL clean_pulse: got %b want 11", {trigger_out, rx_valid});
    end
    checks++;
    if (rx_cmd !== 8'h54) begin
      errors++; $display("FAIL clean_cmd: got %h want 54", rx_cmd);
    end
    checks++;
    if (rx_seq !== 8'h07) begin
      errors++; $display("FAIL clean_seq: got %h want 07", rx_seq);
    end
    @(negedge clk);
    checks++;
    if ({trigger_out, rx_valid} !== 2'b00) begin
      errors++; $display("FAIL clean_width: got %b want 00", {trigger_out, rx_valid});
    end
    idle(20);
    #1;
    checks++;
    if (n_trig - b_trig !== 1) begin
      errors++; $display("FAIL clean_trig_count: got %0d want 1", n_trig - b_trig);
    end
    checks++;
    if (n_valid - b_valid !== 1) begin
      errors++; $display("FAIL clean_valid_count: got %0d want 1", n_valid - b_valid);
    end
    checks++;
    if (n_frame - b_frame + n_crc - b_crc + n_to - b_to !== 0) begin
      errors++; $display("FAIL clean_err_flags: got %0d want 0", n_frame - b_frame + n_crc - b_crc + n_to - b_to);
    end
  endtask

  task automatic test_bad_crc();
    snap();
    send_packet(8'h49, 8'h08, 8'h00);
    idle(20);
    #1;
`ifdef PSC_RX_CRC_EN
    checks++;
    if (n_crc - b_crc !== 1) begin
      errors++; $display("FAIL badcrc_crc_err: got %0d want 1", n_crc - b_crc);
    end
    checks++;
    if (n_valid - b_valid !== 0) begin
      errors++; $display("FAIL badcrc_valid: got %0d want 0", n_valid - b_valid);
    end
    checks++;
    if (rx_seq !== 8'h07) begin
      errors++; $display("FAIL badcrc_seq: got %h want 07", rx_seq);
    end
    checks++;
    if (rx_cmd !== 8'h54) begin
      errors++; $display("FAIL badcrc_cmd: got %h want 54", rx_cmd);
    end
`else
    checks++;
    if (n_valid - b_valid !== 1) begin
      errors++; $display("FAIL nocrc_valid: got %0d want 1", n_valid - b_valid);
    end
    checks++;
    if (n_trig - b_trig !== 0) begin
      errors++; $display("FAIL nocrc_trig: got %0d want 0", n_trig - b_trig);
    end
    checks++;
    if (rx_cmd !== 8'h49) begin
      errors++; $display("FAIL nocrc_cmd: got %h want 49", rx_cmd);
    end
    checks++;
    if (n_crc - b_crc !== 0) begin
      errors++; $display("FAIL nocrc_crc_err: got %0d want 0", n_crc - b_crc);
    end
`endif
  endtask

  task automatic test_frame_error();
    snap();
    send_word(8'hA5);
    send_word(8'h54, 1'b1);
    idle(20);
    #1;
    checks++;
    if (n_frame - b_frame !== 1) begin
      errors++; $display("FAIL frame_err_count: got %0d want 1", n_frame - b_frame);
    end
    checks++;
    if (n_valid - b_valid !== 0) begin
      errors++; $display("FAIL frame_discard: got %0d valid want 0", n_valid - b_valid);
    end
    snap();
    send_packet(8'h54, 8'h07, 8'hC5);
    idle(20);
    #1;
    checks++;
    if (n_trig - b_trig !== 1) begin
      errors++; $display("FAIL frame_recover_trig: got %0d want 1", n_trig - b_trig);
    end
    checks++;
    if (rx_cmd !== 8'h54) begin
      errors++; $display("FAIL frame_recover_cmd: got %h want 54", rx_cmd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [6];
    b = '{8'h3C, 8'hFF, 8'hA5, 8'h54, 8'h07, 8'hC5};
    snap();
    for (int i = 0; i < 6; i++) send_word(b[i]);
    @(negedge clk);
    checks++;
    if (trigger_out !== 1'b1) begin
      errors++; $display("FAIL b2b_trig_timing: got %b want 1", trigger_out);
    end
    idle(20);
    #1;
    checks++;
    if (n_trig - b_trig !== 1) begin
      errors++; $display("FAIL b2b_trig_count: got %0d want 1", n_trig - b_trig);
    end
    checks++;
    if (n_valid - b_valid !== 1) begin
      errors++; $display("FAIL b2b_valid_count: got %0d want 1", n_valid - b_valid);
    end
    checks++;
    if (n_frame - b_frame + n_crc - b_crc !== 0) begin
      errors++; $display("FAIL b2b_err_flags: got %0d want 0", n_frame - b_frame + n_crc - b_crc);
    end
    checks++;
    if (rx_seq !== 8'h07) begin
      errors++; $display("FAIL b2b_seq: got %h want 07", rx_seq);
    end
  endtask

  task automatic test_timeout();
    int k;
    snap();
    send_word(8'hA5);
    send_word(8'h54);
    k = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1 && k == 0) k = i;
    end
    #1;
    checks++;
    if (k < 100 || k > 101) begin
      errors++; $display("FAIL timeout_latency: got %0d clk want 100..101", k);
    end
    checks++;
    if (n_to - b_to !== 1) begin
      errors++; $display("FAIL timeout_count: got %0d want 1", n_to - b_to);
    end
    checks++;
    if (n_valid - b_valid !== 0) begin
      errors++; $display("FAIL timeout_valid: got %0d want 0", n_valid - b_valid);
    end
    snap();
    send_word(8'h07);
    send_word(8'hC5);
    idle(20);
    #1;
    checks++;
    if (n_valid - b_valid !== 0) begin
      errors++; $display("FAIL timeout_hunt: got %0d valid want 0", n_valid - b_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    send_word(8'hA5);
    send_word(8'h54);
    psc_input = 1'b1;
    repeat (OS) @(negedge clk);
    psc_input = 1'b0;
    repeat (2 * OS) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({rx_cmd, rx_seq} !== 16'h0) begin
      errors++; $display("FAIL midreset_fields: got %h want 0000", {rx_cmd, rx_seq});
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({trigger_out, rx_valid, frame_err, crc_err, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL midreset_pulses: got %b want 00000", {trigger_out, rx_valid, frame_err, crc_err, timeout_err});
    end
    reset = 1'b0;
    snap();
    idle(200);
    #1;
    checks++;
    if (n_trig - b_trig + n_valid - b_valid + n_frame - b_frame + n_crc - b_crc + n_to - b_to !== 0) begin
      errors++; $display("FAIL midreset_quiet: got %0d pulses want 0", n_trig - b_trig + n_valid - b_valid + n_frame - b_frame + n_crc - b_crc + n_to - b_to);
    end
    snap();
    send_packet(8'h54, 8'h07, 8'hC5);
    idle(20);
    #1;
    checks++;
    if (n_trig - b_trig !== 1) begin
      errors++; $display("FAIL midreset_trig: got %0d want 1", n_trig - b_trig);
    end
    checks++;
    if ({rx_cmd, rx_seq} !== 16'h5407) begin
      errors++; $display("FAIL midreset_fields_after: got %h want 5407", {rx_cmd, rx_seq});
    end
  endtask

  initial begin
    test_reset();
    test_clean_packet();
    test_bad_crc();
    test_frame_error();
    test_back_to_back();
    test_timeout();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
